// File: rtl/datapath_pkg.sv
// Shared types for the self-sequencing datapath: command opcodes, ALU selects
// and sequencer states.
package datapath_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_ALU   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_INC  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_NOT  = 3'd7
    } alu_sel_e;

    typedef enum logic {
        IDLE    = 1'b0,
        LD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/dp_mem.sv
// Single-port data memory: synchronous write, registered read, no reset on
// contents or read register (contents are undefined until stored).
module dp_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // q only updates on a read so it holds the load data through LD_WAIT
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/datapath_seq.sv
// Register file, ALU and load/store sequencer behind a valid/ready command port.
// Optional condition flags are built when DATAPATH_FLAGS_EN is defined.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_N     = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [$clog2(REG_N)-1:0]     cmd_rd,
    input  logic [$clog2(REG_N)-1:0]     cmd_ra,
    input  logic [$clog2(REG_N)-1:0]     cmd_rb,
    input  logic [2:0]                   cmd_alu_s,
    input  logic [$clog2(MEM_DEPTH)-1:0] cmd_addr,
    output logic                         res_valid,
    output logic [$clog2(REG_N)-1:0]     res_rd,
    output logic [DATA_W-1:0]            res_data,
    output logic                         busy
`ifdef DATAPATH_FLAGS_EN
    ,
    output logic                         flag_z,
    output logic                         flag_n,
    output logic                         flag_c
`endif
);

    localparam int RW = $clog2(REG_N);

    state_e            state_reg, state_next;
    logic              ready_reg;
    logic [RW-1:0]     ld_rd_reg;
    logic [DATA_W-1:0] rf_reg [REG_N];

    logic              accept;
    op_e               op;
    logic [DATA_W-1:0] opa, opb, alu_res, mem_q;
    logic              rf_we, mem_en, mem_we;
    logic [RW-1:0]     rf_wa;
    logic [DATA_W-1:0] rf_wd;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = ready_reg & (state_reg == IDLE);
    assign busy      = (state_reg == LD_WAIT);
    assign accept    = cmd_valid & cmd_ready;
    assign opa       = rf_reg[cmd_ra];
    assign opb       = rf_reg[cmd_rb];

    always_comb begin
        alu_res = opa;
        case (alu_sel_e'(cmd_alu_s))
            ALU_PASS: alu_res = opa;
            ALU_ADD:  alu_res = opa + opb;
            ALU_SUB:  alu_res = opa - opb;
            ALU_INC:  alu_res = opa + DATA_W'(1);
            ALU_AND:  alu_res = opa & opb;
            ALU_OR:   alu_res = opa | opb;
            ALU_XOR:  alu_res = opa ^ opb;
            ALU_NOT:  alu_res = ~opa;
            default:  alu_res = opa;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        rf_we      = 1'b0;
        rf_wa      = '0;
        rf_wd      = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD: begin
                            mem_en     = 1'b1;
                            state_next = LD_WAIT;
                        end
                        OP_STORE: begin
                            mem_en = 1'b1;
                            mem_we = 1'b1;
                        end
                        OP_ALU: begin
                            rf_we = 1'b1;
                            rf_wa = cmd_rd;
                            rf_wd = alu_res;
                        end
                        default: ;
                    endcase
                end
            end
            LD_WAIT: begin
                rf_we      = 1'b1;
                rf_wa      = ld_rd_reg;
                rf_wd      = mem_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
            ld_rd_reg <= '0;
            res_valid <= 1'b0;
            res_rd    <= '0;
            res_data  <= '0;
            for (int i = 0; i < REG_N; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            ready_reg <= 1'b1;
            if (accept && op == OP_LOAD) begin
                ld_rd_reg <= cmd_rd;
            end
            // result strobe reports the write that happens at this same edge
            res_valid <= rf_we;
            if (rf_we) begin
                rf_reg[rf_wa] <= rf_wd;
                res_rd        <= rf_wa;
                res_data      <= rf_wd;
            end
        end
    end

`ifdef DATAPATH_FLAGS_EN
    logic carry;

    // carry derived from the truncated result: overflow of add/inc, not-borrow of sub
    always_comb begin
        carry = 1'b0;
        case (alu_sel_e'(cmd_alu_s))
            ALU_ADD: carry = (alu_res < opa);
            ALU_SUB: carry = (opa >= opb);
            ALU_INC: carry = (opa == {DATA_W{1'b1}});
            default: carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else if (accept && op == OP_ALU && state_reg == IDLE) begin
            flag_z <= (alu_res == '0);
            flag_n <= alu_res[DATA_W-1];
            flag_c <= carry;
        end
    end
`endif

    dp_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (cmd_addr),
        .wdata (opa),
        .q     (mem_q)
    );

endmodule

// File: tb/tb_datapath_seq.sv
// Randomised and directed bench for datapath_seq against a behavioural model
// of registers, memory and flags (flags checked when DATAPATH_FLAGS_EN is set).
module tb_datapath_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [3:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
    logic [2:0] cmd_alu_s = '0;
    logic [7:0] cmd_addr = '0;
    logic       res_valid;
    logic [3:0] res_rd;
    logic [15:0] res_data;
    logic       busy;
`ifdef DATAPATH_FLAGS_EN
    logic       flag_z, flag_n, flag_c;
`endif

    datapath_seq #(.DATA_W(16), .REG_N(16), .MEM_DEPTH(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_alu_s (cmd_alu_s),
        .cmd_addr  (cmd_addr),
        .res_valid (res_valid),
        .res_rd    (res_rd),
        .res_data  (res_data),
        .busy      (busy)
`ifdef DATAPATH_FLAGS_EN
        ,
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c)
`endif
    );

    always #5 clk = ~clk;

    localparam int NOP = 0, LOAD = 1, STORE = 2, ALU = 3;
    localparam int S_PASS = 0, S_ADD = 1, S_SUB = 2, S_INC = 3, S_NOT = 7;

    int errors = 0;
    int checks = 0;
    int last_waits = 0;

    // behavioural state
    int rf_m [16];
    int mem_m [256];
    int stored [$];
    bit fz_m = 0, fn_m = 0, fc_m = 0;
    bit pend_ld = 0;
    int pend_rd = 0, pend_data = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void alu_model(input int s, input int a, input int b,
                                      output int r, output bit c);
        c = 0;
        case (s)
            0: r = a;
            1: begin r = a + b; c = (r > 65535); end
            2: begin r = a - b; c = (a >= b); end
            3: begin r = a + 1; c = (r > 65535); end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = ~a;
        endcase
        r = r & 32'hFFFF;
    endfunction

    task automatic check_flags(input string tag);
`ifdef DATAPATH_FLAGS_EN
        check({tag, "_z"}, 32'(flag_z), 32'(fz_m));
        check({tag, "_n"}, 32'(flag_n), 32'(fn_m));
        check({tag, "_c"}, 32'(flag_c), 32'(fc_m));
`endif
    endtask

    // called #1 after any edge at which no new command was accepted
    task automatic post_check();
        if (pend_ld) begin
            check("ld_valid", 32'(res_valid), 1);
            check("ld_rd", 32'(res_rd), 32'(pend_rd));
            check("ld_data", 32'(res_data), 32'(pend_data));
            check("ld_busy_done", 32'(busy), 0);
            rf_m[pend_rd] = pend_data;
            pend_ld = 0;
        end else begin
            check("idle_valid", 32'(res_valid), 0);
        end
        $display("edge: res_valid=%0d rd=%0d data=%04h busy=%0d", res_valid, res_rd, res_data, busy);
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        post_check();
    endtask

    task automatic send(input int op, input int rd, input int ra, input int rb,
                        input int s, input int addr);
        int waits, r;
        bit c;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_rd    = 4'(rd);
        cmd_ra    = 4'(ra);
        cmd_rb    = 4'(rb);
        cmd_alu_s = 3'(s);
        cmd_addr  = 8'(addr);
        waits = 0;
        while (!cmd_ready && waits < 8) begin
            @(posedge clk);
            #1;
            post_check();
            @(negedge clk);
            waits++;
        end
        last_waits = waits;
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        case (op)
            LOAD: begin
                check("ld_busy", 32'(busy), 1);
                check("ld_ready", 32'(cmd_ready), 0);
                check("ld_no_res", 32'(res_valid), 0);
                pend_ld = 1;
                pend_rd = rd;
                pend_data = mem_m[addr];
            end
            STORE: begin
                check("st_no_res", 32'(res_valid), 0);
                mem_m[addr] = rf_m[ra];
                stored.push_back(addr);
            end
            ALU: begin
                alu_model(s, rf_m[ra], rf_m[rb], r, c);
                check("alu_valid", 32'(res_valid), 1);
                check("alu_rd", 32'(res_rd), 32'(rd));
                check("alu_data", 32'(res_data), 32'(r));
                rf_m[rd] = r;
                fz_m = (r == 0);
                fn_m = r[15];
                fc_m = c;
            end
            default: check("nop_no_res", 32'(res_valid), 0);
        endcase
        check_flags("flags");
        $display("cmd op=%0d rd=%0d ra=%0d rb=%0d s=%0d addr=%0d waits=%0d res_valid=%0d data=%04h",
                 op, rd, ra, rb, s, addr, waits, res_valid, res_data);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) rf_m[i] = 0;
        fz_m = 0; fn_m = 0; fc_m = 0;
        pend_ld = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int op, a;
        reset_model();
        for (int i = 0; i < 256; i++) mem_m[i] = 0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_valid", 32'(res_valid), 0);
        check("rst_data", 32'(res_data), 0);
        check("rst_busy", 32'(busy), 0);
        check_flags("rst_flags");
        rst_n = 1'b1;
        #1;
        check("rel_ready_pre", 32'(cmd_ready), 0);
        @(posedge clk);
        #1;
        check("rel_ready", 32'(cmd_ready), 1);

        // every register reads 0 after reset
        for (int i = 0; i < 16; i++) send(ALU, i, i, 0, S_PASS, 0);

        // store then load through memory
        send(ALU, 1, 0, 0, S_INC, 0);
        send(STORE, 0, 1, 0, 0, 11);
        send(LOAD, 2, 0, 0, 0, 11);
        idle();
        check("ld_addr11_rf2", 32'(rf_m[2]), 1);

        // ALU chain, back-to-back dependent ops without stall
        for (int i = 0; i < 4; i++) send(ALU, 1, 1, 0, S_INC, 0);
        for (int i = 0; i < 2; i++) send(ALU, 2, 2, 0, S_INC, 0);
        send(ALU, 5, 1, 2, S_SUB, 0);
        check("chain_sub", 32'(res_data), 2);
        send(ALU, 0, 5, 5, S_ADD, 0);
        check("chain_add", 32'(res_data), 4);
        check("chain_nostall", 32'(last_waits), 0);

        // wrap and sign
        send(ALU, 3, 4, 0, S_NOT, 0);
        send(ALU, 6, 3, 0, S_INC, 0);
        check("wrap_data", 32'(res_data), 0);
        send(ALU, 7, 2, 1, S_SUB, 0);
        check("neg_data", 32'(res_data), 32'hFFFE);

        // command held through LD_WAIT is taken once, one cycle later
        send(LOAD, 8, 0, 0, 0, 11);
        send(ALU, 9, 8, 1, S_ADD, 0);
        check("held_waits", 32'(last_waits), 1);
        check("held_data", 32'(res_data), 6);
        idle();

        // randomised traffic
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            if (op == 9) idle();
            else if (op == 0) send(NOP, $urandom_range(0, 15), $urandom_range(0, 15), 0, 0, 0);
            else if (op <= 2 && stored.size() > 0) begin
                a = stored[$urandom_range(0, stored.size() - 1)];
                send(LOAD, $urandom_range(0, 15), 0, 0, 0, a);
            end else if (op <= 4)
                send(STORE, 0, $urandom_range(0, 15), 0, 0, $urandom_range(0, 255));
            else
                send(ALU, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 7), 0);
        end
        idle();

        // reset during LD_WAIT aborts the load
        send(ALU, 1, 0, 0, S_NOT, 0);
        send(STORE, 0, 1, 0, 0, 20);
        send(LOAD, 10, 0, 0, 0, 20);
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(cmd_ready), 0);
        check("abort_valid", 32'(res_valid), 0);
        check("abort_data", 32'(res_data), 0);
        reset_model();
        check_flags("abort_flags");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        post_check();
        send(ALU, 10, 10, 0, S_PASS, 0);
        check("abort_rf10", 32'(res_data), 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
